mix_columns_engine: RTL

- Sequential, parametrised MixColumns/InvMixColumns engine that transforms a full 128-bit AES state, not a single 32-bit word.
- Sits between the ShiftRows and AddRoundKey stages of the round datapath.
- Forward or inverse transform is selected per transaction.
- Throughput and area are traded through COLS_PER_CYCLE.
- Valid/ready handshakes are used on both sides.

---
 rtl/aes_gf_pkg.sv | 58 +++++
 rtl/mix_columns_engine_if.sv | 24 ++
 rtl/mix_column_word.sv | 32 +++
 rtl/mix_columns_engine.sv | 112 +++++++++++
 4 files changed

// File: rtl/aes_gf_pkg.sv
// GF(2^8) helpers for the AES MixColumns datapath, plus shared mode and FSM encodings.
package aes_gf_pkg;

  localparam logic MODE_FWD = 1'b0;
  localparam logic MODE_INV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mc_state_e;

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] x);
    return xtime(x);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] x);
    logic [7:0] x8;
    x8 = xtime(xtime(xtime(x)));
    return x8 ^ x;
  endfunction

  function automatic logic [7:0] gf_mulb(input logic [7:0] x);
    logic [7:0] x2;
    logic [7:0] x8;
    x2 = xtime(x);
    x8 = xtime(xtime(x2));
    return x8 ^ x2 ^ x;
  endfunction

  function automatic logic [7:0] gf_muld(input logic [7:0] x);
    logic [7:0] x4;
    logic [7:0] x8;
    x4 = xtime(xtime(x));
    x8 = xtime(x4);
    return x8 ^ x4 ^ x;
  endfunction

  function automatic logic [7:0] gf_mule(input logic [7:0] x);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/mix_columns_engine_if.sv
// Source/sink bundle for mix_columns_engine: one input state channel, one result channel.
interface mix_columns_engine_if;
  // Both channels use valid/ready: a transfer happens on a rising clk edge where
  // valid and ready are both high; a source holds valid and its payload stable
  // until that edge, and ready may depend on state but never on valid.
  logic         in_valid;
  logic         in_ready;
  logic         in_mode;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  modport master (
    output in_valid, in_mode, in_state, out_ready,
    input  in_ready, out_valid, out_state, busy
  );

  modport slave (
    input  in_valid, in_mode, in_state, out_ready,
    output in_ready, out_valid, out_state, busy
  );
endinterface

// File: rtl/mix_column_word.sv
// Combinational MixColumns / InvMixColumns on one 32-bit column (byte 0 = MSB byte).
module mix_column_word
  import aes_gf_pkg::*;
(
  input  logic [31:0] col,
  input  logic        mode,
  output logic [31:0] res
);

  logic [7:0]  a0, a1, a2, a3;
  logic [31:0] fwd;
  logic [31:0] inv;

  assign {a0, a1, a2, a3} = col;

  assign fwd = {
    gf_mul2(a0) ^ gf_mul3(a1) ^ a2          ^ a3,
    a0          ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3,
    a0          ^ a1          ^ gf_mul2(a2) ^ gf_mul3(a3),
    gf_mul3(a0) ^ a1          ^ a2          ^ gf_mul2(a3)
  };

  assign inv = {
    gf_mule(a0) ^ gf_mulb(a1) ^ gf_muld(a2) ^ gf_mul9(a3),
    gf_mul9(a0) ^ gf_mule(a1) ^ gf_mulb(a2) ^ gf_muld(a3),
    gf_muld(a0) ^ gf_mul9(a1) ^ gf_mule(a2) ^ gf_mulb(a3),
    gf_mulb(a0) ^ gf_muld(a1) ^ gf_mul9(a2) ^ gf_mule(a3)
  };

  assign res = (mode == MODE_FWD) ? fwd : inv;

endmodule

// File: rtl/mix_columns_engine.sv
// Sequential MixColumns engine over a full 128-bit AES state, COLS_PER_CYCLE columns per clock.
module mix_columns_engine
  import aes_gf_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1,
  parameter bit OUT_REG        = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  mix_columns_engine_if.slave bus
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $fatal(1, "mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam int            NCYC = 4 / COLS_PER_CYCLE;
  localparam int            CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCYC - 1);

  mc_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic          mode_q;
  logic [127:0]  work_q;
  logic [127:0]  work_nxt;
  logic          last;

  logic [1:0]  col_idx [COLS_PER_CYCLE];
  logic [31:0] col_in  [COLS_PER_CYCLE];
  logic [31:0] col_out [COLS_PER_CYCLE];

  assign last = (cnt_q == LAST);

  // Column c occupies bits [127-32c -: 32]; {~c, 5'h1f} is that MSB index.
  for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_col
    assign col_idx[j] = 2'(int'(cnt_q) * COLS_PER_CYCLE + j);
    assign col_in[j]  = work_q[{~col_idx[j], 5'h1f} -: 32];

    mix_column_word u_word (
      .col  (col_in[j]),
      .mode (mode_q),
      .res  (col_out[j])
    );
  end

  always_comb begin
    work_nxt = work_q;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < COLS_PER_CYCLE; j++) begin
        if (col_idx[j] == 2'(c)) begin
          work_nxt[127 - 32*c -: 32] = col_out[j];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_FWD;
      work_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            work_q  <= bus.in_state;
            mode_q  <= bus.in_mode;
            cnt_q   <= '0;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          work_q <= work_nxt;
          if (last) begin
            cnt_q   <= '0;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // The output register captures the finished state on the last BUSY cycle,
  // so both variants raise out_valid on the same cycle.
  if (OUT_REG) begin : g_out_reg
    logic [127:0] out_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_q <= '0;
      end else if (state_q == ST_BUSY && last) begin
        out_q <= work_nxt;
      end
    end
    assign bus.out_state = out_q;
  end else begin : g_out_work
    assign bus.out_state = work_q;
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);

endmodule
